// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional parity, stop bit.
// One bit is sampled per clock; completed words are presented with a one-cycle valid pulse.
module serial_frame_rx #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_EN  = 1,
    parameter bit ODD_PARITY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!din) begin
                        state <= DATA;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                DATA: begin
                    shreg[cnt] <= din;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= PARITY_EN ? PARITY : STOP;
                end
                PARITY: begin
                    par_bit <= din;
                    state   <= STOP;
                end
                default: begin
                    // Back to IDLE unconditionally; the next cycle may already be a start bit.
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (din) begin
                        valid      <= 1'b1;
                        data_out   <= shreg;
                        parity_err <= PARITY_EN && ((^shreg ^ par_bit) != ODD_PARITY);
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: default parity build plus a no-parity/odd build.
module tb_serial_frame_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       din2 = 1'b1;
    logic [7:0] data_out, data_out2;
    logic       valid, parity_err, frame_err, busy;
    logic       valid2, parity_err2, frame_err2, busy2;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1), .ODD_PARITY(0)) dut (
        .clk(clk), .rst(rst), .din(din), .data_out(data_out), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(0), .ODD_PARITY(1)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .data_out(data_out2), .valid(valid2),
        .parity_err(parity_err2), .frame_err(frame_err2), .busy(busy2)
    );

    // Drive one bit for a cycle; returns #1 after the sampling edge.
    task automatic step(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic b);
        din2 = b;
        @(posedge clk);
        #1;
    endtask

    // Sends start..parity (10 cycles) checking busy=1 and no pulses, then the stop bit.
    // Returns in the cycle where valid/frame_err is expected.
    task automatic send(input logic [7:0] d, input logic p, input logic s, input string nm);
        int bad;
        bad = 0;
        step(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (busy !== 1'b1 || valid !== 1'b0 || frame_err !== 1'b0) bad++;
            step(d[i]);
        end
        if (busy !== 1'b1 || valid !== 1'b0 || frame_err !== 1'b0) bad++;
        step(p);
        if (busy !== 1'b1 || valid !== 1'b0 || frame_err !== 1'b0) bad++;
        step(s);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_inframe: %0d cycles with wrong busy/valid/frame_err, required 0", nm, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1);
        step(1'b1);
        checks++;
        if ({valid, parity_err, frame_err, busy} !== 4'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset: v/pe/fe/busy=%b data=%h, required 0000 data=00",
                     {valid, parity_err, frame_err, busy}, data_out);
        end
        rst = 1'b0;
        step(1'b1);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, valid);
        end
    endtask

    task automatic test_basic();
        int t0;
        t0 = cyc;
        send(8'hA5, 1'b0, 1'b1, "basic");
        checks++;
        if (valid !== 1'b1 || data_out !== 8'hA5 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_word: valid=%b data=%h pe=%b fe=%b, required 1 a5 0 0",
                     valid, data_out, parity_err, frame_err);
        end
        checks++;
        if (cyc - t0 != 11) begin
            errors++;
            $display("FAIL basic_latency: %0d cycles, required 11", cyc - t0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_end: busy=%b, required 0", busy);
        end
        step(1'b1);
        checks++;
        if (valid !== 1'b0 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL basic_pulse: valid=%b data=%h, required 0 a5", valid, data_out);
        end
    endtask

    task automatic test_parity_err();
        send(8'h3C, 1'b1, 1'b1, "parity");
        checks++;
        if (valid !== 1'b1 || parity_err !== 1'b1 || data_out !== 8'h3C || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_err: valid=%b pe=%b data=%h fe=%b, required 1 1 3c 0",
                     valid, parity_err, data_out, frame_err);
        end
        step(1'b1);
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_pulse: pe=%b, required 0", parity_err);
        end
    endtask

    task automatic test_frame_err();
        send(8'hA5, 1'b0, 1'b1, "fe_pre");
        step(1'b1);
        send(8'h55, 1'b0, 1'b0, "fe");
        checks++;
        if (frame_err !== 1'b1 || valid !== 1'b0 || parity_err !== 1'b0 || data_out !== 8'hA5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_err: fe=%b valid=%b pe=%b data=%h busy=%b, required 1 0 0 a5 0",
                     frame_err, valid, parity_err, data_out, busy);
        end
        step(1'b1);
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_pulse: fe=%b busy=%b, required 0 0", frame_err, busy);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        send(8'h12, 1'b0, 1'b1, "b2b_a");
        t1 = cyc;
        checks++;
        if (valid !== 1'b1 || data_out !== 8'h12 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: valid=%b data=%h pe=%b, required 1 12 0", valid, data_out, parity_err);
        end
        send(8'hF0, 1'b0, 1'b1, "b2b_b");
        checks++;
        if (valid !== 1'b1 || data_out !== 8'hF0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b data=%h pe=%b fe=%b, required 1 f0 0 0",
                     valid, data_out, parity_err, frame_err);
        end
        checks++;
        if (cyc - t1 != 11) begin
            errors++;
            $display("FAIL b2b_spacing: %0d cycles, required 11", cyc - t1);
        end
        step(1'b1);
    endtask

    task automatic test_reset_midframe();
        int bad;
        bad = 0;
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || data_out !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset: busy=%b data=%h valid=%b fe=%b, required 0 00 0 0",
                     busy, data_out, valid, frame_err);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b1);
            if (valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_quiet: %0d cycles with pulses/busy, required 0", bad);
        end
        send(8'h0F, 1'b0, 1'b1, "post_reset");
        checks++;
        if (valid !== 1'b1 || data_out !== 8'h0F || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_word: valid=%b data=%h pe=%b, required 1 0f 0", valid, data_out, parity_err);
        end
        step(1'b1);
    endtask

    task automatic test_no_parity();
        logic [7:0] d;
        int t0;
        d = 8'h81;
        t0 = cyc;
        step2(1'b0);
        for (int i = 0; i < 8; i++) step2(d[i]);
        step2(1'b1);
        checks++;
        if (cyc - t0 != 10 || valid2 !== 1'b1 || data_out2 !== 8'h81 || parity_err2 !== 1'b0) begin
            errors++;
            $display("FAIL no_parity: lat=%0d valid=%b data=%h pe=%b, required 10 1 81 0",
                     cyc - t0, valid2, data_out2, parity_err2);
        end
        step2(1'b1);
        checks++;
        if (valid2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL no_parity_pulse: valid=%b busy=%b, required 0 0", valid2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        test_no_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
